// File: rtl/types_pkg.sv
// Shared types for the experiment front end.
// Channel map, conditioned input bundle, counter arrays.
package types_pkg;

  localparam int N_INPUT_CH   = 5;

  localparam int CH_START     = 0;
  localparam int CH_FG_OPTO   = 1;
  localparam int CH_FG_OPEN   = 2;
  localparam int CH_WIRE      = 3;
  localparam int CH_DET_READY = 4;

  localparam int CNT_W_DEF    = 16;

  localparam logic [N_INPUT_CH-1:0] RESET_LEVEL_DEF = 5'b10000;

  // First member is the MSB, so channel 0 lands in bit 0.
  typedef struct packed {
    logic detector_ready;
    logic wire_sensor;
    logic fg_open;
    logic fg_opto;
    logic start;
  } input_signals_t;

  typedef logic [N_INPUT_CH-1:0][CNT_W_DEF-1:0] glitch_cnt_t;

  function automatic input_signals_t pack_inputs(
    input logic [N_INPUT_CH-1:0] lv
  );
    input_signals_t p;
    p.start          = lv[CH_START];
    p.fg_opto        = lv[CH_FG_OPTO];
    p.fg_open        = lv[CH_FG_OPEN];
    p.wire_sensor    = lv[CH_WIRE];
    p.detector_ready = lv[CH_DET_READY];
    return p;
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioned input: synchroniser, persistence filter,
// edge strobes and a saturating rejected-glitch counter.
module debounce_channel
  import types_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 20,
  parameter int   CNT_W       = 16,
  parameter logic RESET_BIT   = 1'b0
) (
  input  logic             clock,
  input  logic             reset_signal,
  input  logic             raw,
  input  logic             clear_cnt,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam bit BYPASS   = (FILTER_LEN <= 1);
  localparam int RUN_W    = BYPASS ? 1 : $clog2(FILTER_LEN);
  localparam int RUN_LAST = BYPASS ? 0 : FILTER_LEN - 1;

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LAST);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic             level_d;
  logic             rise_d;
  logic             fall_d;
  logic             glitch_hit;

  assign s = sync_q[SYNC_STAGES-1];

  // Plain shift chain; the reset value matches the idle level.
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      sync_q <= {SYNC_STAGES{RESET_BIT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Accept a new level only after it persists for the full run.
  always_comb begin
    run_d      = run_q;
    level_d    = level;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_hit = 1'b0;
    if (BYPASS) begin
      run_d   = '0;
      level_d = s;
      rise_d  = s & ~level;
      fall_d  = ~s & level;
    end else if (s == level) begin
      run_d      = '0;
      glitch_hit = (run_q != '0);
    end else if (run_q == RUN_MAX) begin
      run_d   = '0;
      level_d = s;
      rise_d  = s;
      fall_d  = ~s;
    end else begin
      run_d = run_q + RUN_W'(1);
    end
  end

  // Filter state and registered strobes; reset drops any partial run.
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      run_q <= '0;
      level <= RESET_BIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      run_q <= run_d;
      level <= level_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

  // Saturating count of rejected pulses; clear beats increment.
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      glitch_cnt <= '0;
    end else if (clear_cnt) begin
      glitch_cnt <= '0;
    end else if (glitch_hit && glitch_cnt != CNT_MAX) begin
      glitch_cnt <= glitch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Front end for fsm_experiment: conditions every raw field
// input and packs the clean levels into the input bundle.
module input_conditioner
  import types_pkg::*;
#(
  parameter int N_CH        = N_INPUT_CH,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 20,
  parameter int CNT_W       = CNT_W_DEF,
  parameter logic [N_CH-1:0] RESET_LEVEL = RESET_LEVEL_DEF
) (
  input  logic                       clock,
  input  logic                       reset_signal,
  input  logic [N_CH-1:0]            raw,
  input  logic                       clear_cnt,
  output logic [N_CH-1:0]            level,
  output logic [N_CH-1:0]            rise,
  output logic [N_CH-1:0]            fall,
  output logic [N_CH-1:0][CNT_W-1:0] glitch_cnt,
  output input_signals_t             in_cond
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .CNT_W       (CNT_W),
      .RESET_BIT   (RESET_LEVEL[i])
    ) u_ch (
      .clock        (clock),
      .reset_signal (reset_signal),
      .raw          (raw[i]),
      .clear_cnt    (clear_cnt),
      .level        (level[i]),
      .rise         (rise[i]),
      .fall         (fall[i]),
      .glitch_cnt   (glitch_cnt[i])
    );
  end

  assign in_cond = pack_inputs(level);

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner.
// Strobes are predicted at drive time and matched on output.
`timescale 1ns/1ps
module tb_input_conditioner;
  import types_pkg::*;

  localparam int NC  = 5;
  localparam int CW  = 4;
  localparam int LAT = 22;

  logic                   clock = 1'b0;
  logic                   reset_signal;
  logic [NC-1:0]          raw;
  logic                   clear_cnt;
  logic [NC-1:0]          level;
  logic [NC-1:0]          rise;
  logic [NC-1:0]          fall;
  logic [NC-1:0][CW-1:0]  glitch_cnt;
  input_signals_t         in_cond;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  int exp_q[NC][$];

  input_conditioner #(
    .N_CH        (NC),
    .SYNC_STAGES (2),
    .FILTER_LEN  (20),
    .CNT_W       (CW),
    .RESET_LEVEL (5'b10000)
  ) dut (
    .clock        (clock),
    .reset_signal (reset_signal),
    .raw          (raw),
    .clear_cnt    (clear_cnt),
    .level        (level),
    .rise         (rise),
    .fall         (fall),
    .glitch_cnt   (glitch_cnt),
    .in_cond      (in_cond)
  );

  always #2.5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected strobe: cycle number * 2, plus 1 for rise.
  task automatic push(input int ch, input int at, input bit r);
    exp_q[ch].push_back(at * 2 + int'(r));
  endtask

  initial begin : mon
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (mon_en) begin
        chk("in_cond", in_cond, {27'd0, level});
        for (int i = 0; i < NC; i++) begin
          if (rise[i] && fall[i])
            chk($sformatf("both%0d", i), 1, 0);
          if (rise[i] || fall[i]) begin
            if (exp_q[i].size() == 0)
              chk($sformatf("spur%0d", i),
                  cyc * 2 + int'(rise[i]), 32'hffff_ffff);
            else
              chk($sformatf("strobe%0d", i),
                  cyc * 2 + int'(rise[i]), exp_q[i].pop_front());
          end
        end
      end
    end
  end

  initial begin : stim
    raw          = 5'b10000;
    clear_cnt    = 1'b0;
    reset_signal = 1'b1;

    // T1 reset
    repeat (3) tick();
    chk("rst_level", level, 5'b10000);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    for (int i = 0; i < NC; i++)
      chk($sformatf("rst_cnt%0d", i), glitch_cnt[i], 0);
    reset_signal = 1'b0;
    mon_en = 1'b1;
    repeat (30) tick();
    chk("idle_level", level, 5'b10000);

    // T2 clean edge on start
    raw[0] = 1'b1;
    push(0, cyc + LAT, 1'b1);
    repeat (LAT - 1) tick();
    chk("t2_pre", level[0], 0);
    tick();
    chk("t2_lat", level[0], 1);
    repeat (178) tick();
    raw[0] = 1'b0;
    push(0, cyc + LAT, 1'b0);
    repeat (40) tick();
    chk("t2_back", level[0], 0);

    // T3 glitch boundary on wire_sensor
    raw[3] = 1'b1;
    repeat (19) tick();
    raw[3] = 1'b0;
    repeat (40) tick();
    chk("t3_lvl19", level[3], 0);
    chk("t3_cnt19", glitch_cnt[3], 1);
    raw[3] = 1'b1;
    push(3, cyc + LAT, 1'b1);
    repeat (20) tick();
    raw[3] = 1'b0;
    push(3, cyc + LAT, 1'b0);
    repeat (50) tick();
    chk("t3_cnt20", glitch_cnt[3], 1);
    chk("t3_lvl20", level[3], 0);

    // T4 fg_opto square wave
    for (int p = 0; p < 4; p++) begin
      raw[1] = 1'b1;
      push(1, cyc + LAT, 1'b1);
      repeat (500) tick();
      raw[1] = 1'b0;
      push(1, cyc + LAT, 1'b0);
      repeat (500) tick();
    end
    chk("t4_lvl", level[1], 0);

    // T5 saturation and clear priority on fg_open
    for (int g = 0; g < 20; g++) begin
      raw[2] = 1'b1;
      repeat (5) tick();
      raw[2] = 1'b0;
      repeat (10) tick();
      if (g == 9) chk("t5_cnt10", glitch_cnt[2], 10);
    end
    chk("t5_sat", glitch_cnt[2], 15);
    chk("t5_lvl", level[2], 0);
    raw[2] = 1'b1;
    repeat (5) tick();
    raw[2] = 1'b0;
    repeat (2) tick();
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    chk("t5_clr", glitch_cnt[2], 0);
    chk("t5_clr3", glitch_cnt[3], 0);
    raw[2] = 1'b1;
    repeat (3) tick();
    raw[2] = 1'b0;
    repeat (10) tick();
    chk("t5_again", glitch_cnt[2], 1);

    // T6 reset in the middle of a detector_ready run
    raw[4] = 1'b0;
    repeat (12) tick();
    reset_signal = 1'b1;
    repeat (2) tick();
    chk("t6_rst_lvl", level[4], 1);
    reset_signal = 1'b0;
    push(4, cyc + LAT, 1'b0);
    repeat (LAT - 1) tick();
    chk("t6_pre", level[4], 1);
    tick();
    chk("t6_fall", level[4], 0);
    repeat (20) tick();

    mon_en = 1'b0;
    for (int i = 0; i < NC; i++)
      chk($sformatf("left%0d", i), exp_q[i].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
